// File: rtl/map_store.sv
// ============================================================================
// Module   : map_store
// Purpose  : Writable wall map for the tracer; rows loaded over a serial port
//            are staged and committed only while vsync is high.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module map_store #(
    parameter int MAP_WIDTH_BITS  = 4,
    parameter int MAP_HEIGHT_BITS = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vsync,
    input  logic [MAP_WIDTH_BITS-1:0]  i_map_col,
    input  logic [MAP_HEIGHT_BITS-1:0] i_map_row,
    output logic                       o_map_val,
    input  logic                       spi_sclk,
    input  logic                       spi_csb,
    input  logic                       spi_mosi,
    output logic                       o_pending
);

    localparam int c_W         = 1 << MAP_WIDTH_BITS;
    localparam int c_H         = 1 << MAP_HEIGHT_BITS;
    localparam int c_FRAME_LEN = MAP_HEIGHT_BITS + c_W;
    localparam int c_CNT_W     = $clog2(c_FRAME_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    function automatic logic [c_W-1:0] f_reset_row(input int row);
        logic [c_W-1:0] v;
        if (row == 0 || row == c_H - 1) begin
            v = '1;
        end else begin
            v          = '0;
            v[0]       = 1'b1;
            v[c_W-1]   = 1'b1;
        end
        return v;
    endfunction

    logic [c_W-1:0]             r_map [c_H];
    logic                       r_sclk_s1, r_sclk_s2, r_sclk_h;
    logic                       r_csb_s1,  r_csb_s2,  r_csb_h;
    logic                       r_mosi_s1, r_mosi_s2;
    state_t                     r_state, w_state_nxt;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [c_FRAME_LEN-1:0]     r_shift;
    logic                       r_stage_go;
    logic [MAP_HEIGHT_BITS-1:0] r_pend_row;
    logic [c_W-1:0]             r_pend_data;
    logic                       r_pend_valid;

    logic w_sclk_rise, w_csb_fall, w_csb_rise;
    logic w_clr, w_shift, w_stage;

    // Two-flop synchronisers plus a history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_h  <= 1'b0;
            r_csb_s1  <= 1'b1;
            r_csb_s2  <= 1'b1;
            r_csb_h   <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= spi_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_h  <= r_sclk_s2;
            r_csb_s1  <= spi_csb;
            r_csb_s2  <= r_csb_s1;
            r_csb_h   <= r_csb_s2;
            r_mosi_s1 <= spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_h;
    assign w_csb_fall  = ~r_csb_s2 & r_csb_h;
    assign w_csb_rise  = r_csb_s2 & ~r_csb_h;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_shift     = 1'b0;
        w_stage     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_csb_fall) begin
                    w_state_nxt = S_SHIFT;
                    w_clr       = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_csb_rise) begin
                    w_state_nxt = S_IDLE;
                    w_stage     = (r_cnt == c_CNT_FULL);
                end else if (w_sclk_rise && !r_csb_s2) begin
                    if (r_cnt == c_CNT_FULL) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            S_ERROR: begin
                if (w_csb_rise) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_stage_go <= 1'b0;
        end else begin
            r_stage_go <= w_stage;
            if (w_clr) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_shift) begin
                r_cnt   <= r_cnt + 1'b1;
                r_shift <= {r_shift[c_FRAME_LEN-2:0], r_mosi_s2};
            end
        end
    end

    // Staging is one cycle behind frame completion; the shift register
    // is untouched in IDLE so its contents are still the completed frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_row   <= '0;
            r_pend_data  <= '0;
            r_pend_valid <= 1'b0;
        end else if (r_stage_go) begin
            r_pend_row   <= r_shift[c_FRAME_LEN-1 -: MAP_HEIGHT_BITS];
            r_pend_data  <= r_shift[c_W-1:0];
            r_pend_valid <= 1'b1;
        end else if (vsync && r_pend_valid) begin
            r_pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < c_H; r++) begin
                r_map[r] <= f_reset_row(r);
            end
        end else if (vsync && r_pend_valid) begin
            r_map[r_pend_row] <= r_pend_data;
        end
    end

    assign o_map_val = r_map[i_map_row][i_map_col];
    assign o_pending = r_pend_valid;

endmodule

`default_nettype wire
